// File: rtl/serial_cmp_accumulator_if.sv
// Handshake and result bundle between a chunk-result source and serial_cmp_accumulator.
// The master side supplies start and chunk codes; the slave side returns status and the wide result.
interface serial_cmp_accumulator_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             chunk_valid;
    logic             gt_in;
    logic             lt_in;
    logic             eq_in;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             err;
    logic [CNT_W-1:0] chunk_cnt;

    modport master (
        output start, chunk_valid, gt_in, lt_in, eq_in,
        input  busy, done, gt, lt, eq, err, chunk_cnt
    );

    modport slave (
        input  start, chunk_valid, gt_in, lt_in, eq_in,
        output busy, done, gt, lt, eq, err, chunk_cnt
    );
endinterface

// File: rtl/serial_cmp_accumulator.sv
// Folds MSB-first per-chunk gt/lt/eq codes into one wide magnitude-compare result.
// The first legal non-equal chunk decides; non-one-hot codes flag err and void the result.
module serial_cmp_accumulator #(
    parameter int unsigned NUM_CHUNKS = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_cmp_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             decided, decided_n;
    logic             gt_q, gt_n;
    logic             lt_q, lt_n;
    logic             eq_q, eq_n;
    logic             err_q, err_n;
    logic [2:0]       code;
    logic             legal;

    assign code  = {bus.gt_in, bus.lt_in, bus.eq_in};
    assign legal = (code == 3'b100) || (code == 3'b010) || (code == 3'b001);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            decided <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            decided <= decided_n;
            gt_q    <= gt_n;
            lt_q    <= lt_n;
            eq_q    <= eq_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        decided_n = decided;
        gt_n      = gt_q;
        lt_n      = lt_q;
        eq_n      = eq_q;
        err_n     = err_q;

        // start wins in every state; a chunk presented alongside it is dropped
        if (bus.start) begin
            state_n   = ACCUM;
            cnt_n     = '0;
            decided_n = 1'b0;
            gt_n      = 1'b0;
            lt_n      = 1'b0;
            eq_n      = 1'b0;
            err_n     = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ACCUM: begin
                    if (bus.chunk_valid) begin
                        if (!legal) begin
                            err_n = 1'b1;
                        end else if (!decided && (bus.gt_in || bus.lt_in)) begin
                            gt_n      = bus.gt_in;
                            lt_n      = bus.lt_in;
                            decided_n = 1'b1;
                        end
                        // Final flags are resolved on the accepting edge so they are valid during DONE
                        if (cnt == LAST_CNT) begin
                            state_n = DONE;
                            if (err_n) begin
                                gt_n = 1'b0;
                                lt_n = 1'b0;
                                eq_n = 1'b0;
                            end else begin
                                eq_n = !decided_n;
                            end
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == ACCUM);
    assign bus.done      = (state == DONE);
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.err       = err_q;
    assign bus.chunk_cnt = cnt;
endmodule

// File: tb/tb_serial_cmp_accumulator.sv
// Directed bench for serial_cmp_accumulator: reset, decisions, gaps, error codes,
// aborts and back-to-back starts, with hand-computed expectations.
module tb_serial_cmp_accumulator;
    localparam int unsigned NUM_CHUNKS = 4;
    localparam int unsigned CNT_W      = 8;

    localparam logic [2:0] C_GT = 3'b100;
    localparam logic [2:0] C_LT = 3'b010;
    localparam logic [2:0] C_EQ = 3'b001;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_cmp_accumulator_if #(.CNT_W(CNT_W)) bus ();

    serial_cmp_accumulator #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags packed as {busy,done,gt,lt,eq,err}
    task automatic chk_all(input string tag, input logic [5:0] exp_flags, input int exp_cnt);
        chk({tag, ".flags"}, {26'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err},
            {26'd0, exp_flags});
        chk({tag, ".cnt"}, {24'd0, bus.chunk_cnt}, exp_cnt);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chunk(input logic [2:0] c);
        bus.chunk_valid = 1'b1;
        {bus.gt_in, bus.lt_in, bus.eq_in} = c;
        tick();
        bus.chunk_valid = 1'b0;
        {bus.gt_in, bus.lt_in, bus.eq_in} = 3'b000;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.chunk_valid = 1'b0;
        {bus.gt_in, bus.lt_in, bus.eq_in} = 3'b000;
        tick();
        chk_all("reset", 6'b000000, 0);
        rst = 1'b0;
        tick();

        // 1: reset mid-ACCUM after two chunks
        do_start();
        chunk(C_GT);
        chunk(C_EQ);
        chk_all("t1.pre", 6'b101000, 2);
        rst = 1'b1;
        #1;
        chk_all("t1.async", 6'b000000, 0);
        tick();
        rst = 1'b0;
        chk_all("t1.rst", 6'b000000, 0);
        chunk(C_GT);
        chk_all("t1.ignored", 6'b000000, 0);

        // 2: A=8'h2C vs B=8'h29 -> eq,eq,gt,lt
        do_start();
        chk_all("t2.start", 6'b100000, 0);
        chunk(C_EQ);
        chunk(C_EQ);
        chunk(C_GT);
        chk_all("t2.c3", 6'b101000, 3);
        chunk(C_LT);
        chk_all("t2.done", 6'b011000, 3);
        tick();
        chk_all("t2.hold", 6'b001000, 3);

        // 3: four eq chunks with two idle cycles between each
        do_start();
        chunk(C_EQ);
        tick();
        tick();
        chk_all("t3.gap", 6'b100000, 1);
        chunk(C_EQ);
        tick();
        tick();
        chunk(C_EQ);
        tick();
        tick();
        chk_all("t3.gap2", 6'b100000, 3);
        chunk(C_EQ);
        chk_all("t3.done", 6'b010010, 3);

        // 4: first decision sticks
        tick();
        do_start();
        chunk(C_LT);
        chunk(C_GT);
        chunk(C_GT);
        chunk(C_GT);
        chk_all("t4.done", 6'b010100, 3);

        // 5: illegal 110 at chunk 1 voids an earlier gt decision
        tick();
        do_start();
        chunk(C_GT);
        chunk(3'b110);
        chk("t5.err_early", {31'd0, bus.err}, 32'd1);
        chunk(C_EQ);
        chunk(C_EQ);
        chk_all("t5.done", 6'b010001, 3);
        tick();
        chk_all("t5.hold", 6'b000001, 3);
        do_start();
        chk_all("t5.clear", 6'b100000, 0);

        // 5b: all-zero code also flags err
        chunk(C_LT);
        chunk(3'b000);
        chunk(C_EQ);
        chunk(C_EQ);
        chk_all("t5b.done", 6'b010001, 3);

        // 6: start with chunk_valid mid-ACCUM drops that chunk and restarts
        tick();
        do_start();
        chunk(C_GT);
        chunk(C_GT);
        bus.start = 1'b1;
        chunk(C_GT);
        bus.start = 1'b0;
        chk_all("t6.abort", 6'b100000, 0);
        chunk(C_EQ);
        chunk(C_EQ);
        chunk(C_EQ);
        chunk(C_EQ);
        chk_all("t6.done", 6'b010010, 3);
        // start during the DONE cycle
        do_start();
        chk_all("t6.restart", 6'b100000, 0);
        chunk(C_LT);
        chunk(C_EQ);
        chunk(C_EQ);
        chunk(C_EQ);
        chk_all("t6.done2", 6'b010100, 3);
        tick();
        chk_all("t6.idle", 6'b000100, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
